// File: rtl/dmem_lsu.sv
// Load/store unit: aligns and strobes datapath accesses onto a word-addressed
// valid/ready data memory and returns extended load data with a one-cycle response.
module dmem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg;
  logic        we_reg, uns_reg;
  logic [1:0]  size_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic        error_reg, error_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic        accept, misaligned, timeout_hit;
  logic [1:0]  off;
  logic [31:0] sh, load_data;

  assign accept      = (state_reg == IDLE) && req_valid;
  assign misaligned  = (req_size == 2'd3) ||
                       (req_size == 2'd1 && req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  // Compare against limit-1 so the 8-bit counter never has to hold 255+1.
  assign timeout_hit = (cnt_reg == 8'(TIMEOUT_CYCLES - 1));
  assign off         = addr_reg[1:0];
  assign sh          = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = mem_rdata;
    case (size_reg)
      2'd0:    load_data = {{24{~uns_reg & sh[7]}}, sh[7:0]};
      2'd1:    load_data = {{16{~uns_reg & sh[15]}}, sh[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    error_next = error_reg;
    cnt_next   = 8'd0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          rdata_next = 32'd0;
          error_next = misaligned;
          state_next = misaligned ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_next = cnt_reg + 8'd1;
        if (mem_ready) begin
          state_next = we_reg ? RESP : WAIT_R;
        end else if (timeout_hit) begin
          error_next = 1'b1;
          state_next = RESP;
        end
      end
      WAIT_R: begin
        cnt_next = cnt_reg + 8'd1;
        if (mem_rvalid) begin
          rdata_next = load_data;
          state_next = RESP;
        end else if (timeout_hit) begin
          error_next = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      rdata_reg <= 32'd0;
      error_reg <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      error_reg <= error_next;
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        we_reg    <= req_we;
        uns_reg   <= req_unsigned;
        size_reg  <= req_size;
      end
    end
  end

  // Memory-side fields are only presented while a transaction is outstanding.
  always_comb begin
    mem_addr  = 32'd0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    if (state_reg == ISSUE) begin
      mem_addr = {addr_reg[31:2], 2'b00};
      mem_we   = we_reg;
      case (size_reg)
        2'd0: begin
          mem_be    = 4'b0001 << off;
          mem_wdata = {4{wdata_reg[7:0]}};
        end
        2'd1: begin
          mem_be    = 4'b0011 << off;
          mem_wdata = {2{wdata_reg[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_reg;
        end
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign mem_valid  = (state_reg == ISSUE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_error = error_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a default-limit instance for data paths and a
// short-limit instance (sharing the same stimulus) for the timeout behaviour.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, resp_error, mem_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        to_req_ready, to_resp_valid, to_resp_error, to_mem_valid, to_mem_we;
  logic [31:0] to_resp_rdata, to_mem_addr, to_mem_wdata;
  logic [3:0]  to_mem_be;

  int checks = 0;
  int failures = 0;

  dmem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  dmem_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(to_req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(to_resp_valid), .resp_rdata(to_resp_rdata), .resp_error(to_resp_error),
    .mem_valid(to_mem_valid), .mem_ready(mem_ready), .mem_addr(to_mem_addr), .mem_we(to_mem_we),
    .mem_be(to_mem_be), .mem_wdata(to_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 0; req_we = 0; req_unsigned = 0; req_addr = 0;
    req_wdata = 0; req_size = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({resp_error, resp_rdata} !== 33'd0) begin failures++; $display("FAIL reset_resp got=%b/%h exp=0/0", resp_error, resp_rdata); end
    checks++; if ({mem_be, mem_addr, mem_wdata, mem_we} !== 69'd0) begin failures++; $display("FAIL reset_mem_bus got be=%b addr=%h wdata=%h we=%b exp=0", mem_be, mem_addr, mem_wdata, mem_we); end
    checks++; if (to_req_ready !== 1'b1) begin failures++; $display("FAIL reset_to_req_ready got=%b exp=1", to_req_ready); end
    tick;
    rst = 1'b1;
    tick;
    $display("reset: done");
  endtask

  task automatic do_store(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input int hold,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    req_valid = 1; req_addr = addr; req_we = 1; req_size = size; req_unsigned = 0; req_wdata = wdata;
    mem_ready = (hold == 0);
    tick;
    // Leftover request while busy must be ignored; present a different one.
    req_valid = (hold > 0); req_addr = 32'hFFFF_FFF0; req_wdata = 32'h1111_1111; req_size = 2'd2;
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL %s_mem_valid got=%b exp=1", name, mem_valid); end
    checks++; if (mem_addr !== {addr[31:2], 2'b00}) begin failures++; $display("FAIL %s_mem_addr got=%h exp=%h", name, mem_addr, {addr[31:2], 2'b00}); end
    checks++; if (mem_be !== exp_be) begin failures++; $display("FAIL %s_mem_be got=%b exp=%b", name, mem_be, exp_be); end
    checks++; if (mem_wdata !== exp_wdata) begin failures++; $display("FAIL %s_mem_wdata got=%h exp=%h", name, mem_wdata, exp_wdata); end
    checks++; if ({mem_we, req_ready} !== 2'b10) begin failures++; $display("FAIL %s_we_ready got=%b%b exp=10", name, mem_we, req_ready); end
    for (int i = 0; i < hold; i++) begin
      tick;
      checks++; if (mem_valid !== 1'b1 || mem_addr !== {addr[31:2], 2'b00} || mem_wdata !== exp_wdata || req_ready !== 1'b0)
        begin failures++; $display("FAIL %s_hold got valid=%b addr=%h wdata=%h ready=%b exp 1/%h/%h/0", name, mem_valid, mem_addr, mem_wdata, req_ready, {addr[31:2], 2'b00}, exp_wdata); end
    end
    mem_ready = 1; req_valid = 0;
    tick;
    mem_ready = 0;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL %s_resp_valid got=%b exp=1", name, resp_valid); end
    checks++; if ({resp_error, resp_rdata} !== 33'd0) begin failures++; $display("FAIL %s_resp got err=%b rdata=%h exp=0/0", name, resp_error, resp_rdata); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL %s_mem_valid_after got=%b exp=0", name, mem_valid); end
    tick;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL %s_after_resp got valid=%b ready=%b exp=0/1", name, resp_valid, req_ready); end
    $display("store %s: addr=%h be=%b wdata=%h", name, addr, exp_be, exp_wdata);
  endtask

  task automatic do_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                         input logic [3:0] exp_be, input logic [31:0] exp);
    req_valid = 1; req_addr = addr; req_we = 0; req_size = size; req_unsigned = uns; req_wdata = 32'hDEAD_BEEF;
    mem_ready = 0;
    tick;
    req_valid = 0; req_addr = 32'hFFFF_FFFF; req_size = 2'd3; req_unsigned = ~uns;
    checks++; if (mem_valid !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL %s_issue got valid=%b we=%b exp=1/0", name, mem_valid, mem_we); end
    checks++; if (mem_addr !== {addr[31:2], 2'b00} || mem_be !== exp_be) begin failures++; $display("FAIL %s_addr_be got=%h/%b exp=%h/%b", name, mem_addr, mem_be, {addr[31:2], 2'b00}, exp_be); end
    // Read data appearing before the handshake must not be taken.
    mem_rvalid = (rdy_dly > 0); mem_rdata = 32'h5A5A_5A5A;
    repeat (rdy_dly) tick;
    mem_ready = 1; mem_rvalid = 0;
    tick;
    mem_ready = 0;
    checks++; if ({mem_valid, resp_valid} !== 2'b00) begin failures++; $display("FAIL %s_wait got valid=%b resp=%b exp=0/0", name, mem_valid, resp_valid); end
    repeat (rv_dly - 1) tick;
    mem_rvalid = 1; mem_rdata = rdata;
    tick;
    mem_rvalid = 0; mem_rdata = 32'h0;
    checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin failures++; $display("FAIL %s_resp got valid=%b err=%b exp=1/0", name, resp_valid, resp_error); end
    checks++; if (resp_rdata !== exp) begin failures++; $display("FAIL %s_rdata got=%h exp=%h", name, resp_rdata, exp); end
    tick;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL %s_after_resp got valid=%b ready=%b exp=0/1", name, resp_valid, req_ready); end
    $display("load %s: addr=%h mem=%h rdata=%h", name, addr, rdata, resp_rdata);
  endtask

  task automatic do_err(input string name, input logic [31:0] addr, input logic we, input logic [1:0] size);
    req_valid = 1; req_addr = addr; req_we = we; req_size = size; req_unsigned = 0; req_wdata = 32'hCAFE_F00D;
    mem_ready = 1;
    tick;
    req_valid = 0;
    checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin failures++; $display("FAIL %s_resp got valid=%b err=%b exp=1/1", name, resp_valid, resp_error); end
    checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL %s_rdata got=%h exp=00000000", name, resp_rdata); end
    checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL %s_bus got valid=%b ready=%b exp=0/0", name, mem_valid, req_ready); end
    tick;
    mem_ready = 0;
    checks++; if ({mem_valid, resp_valid, req_ready} !== 3'b001) begin failures++; $display("FAIL %s_after got valid=%b resp=%b ready=%b exp=0/0/1", name, mem_valid, resp_valid, req_ready); end
    $display("error %s: addr=%h size=%0d", name, addr, size);
  endtask

  task automatic test_timeout;
    req_valid = 1; req_addr = 32'h0000_0010; req_we = 0; req_size = 2'd2; req_unsigned = 0;
    mem_ready = 0; mem_rvalid = 0;
    tick;
    req_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (to_mem_valid !== 1'b1 || to_resp_valid !== 1'b0) begin failures++; $display("FAIL timeout_issue_c%0d got valid=%b resp=%b exp=1/0", c, to_mem_valid, to_resp_valid); end
      tick;
    end
    checks++; if (to_resp_valid !== 1'b1 || to_resp_error !== 1'b1) begin failures++; $display("FAIL timeout_resp got valid=%b err=%b exp=1/1", to_resp_valid, to_resp_error); end
    checks++; if (to_mem_valid !== 1'b0 || to_resp_rdata !== 32'd0) begin failures++; $display("FAIL timeout_bus got valid=%b rdata=%h exp=0/0", to_mem_valid, to_resp_rdata); end
    tick;
    checks++; if ({to_req_ready, to_resp_valid} !== 2'b10) begin failures++; $display("FAIL timeout_after got ready=%b resp=%b exp=1/0", to_req_ready, to_resp_valid); end
    $display("timeout: load addr=00000010 aborted");
  endtask

  task automatic test_reset_mid;
    rst = 0;
    tick;
    rst = 1;
    tick;
    req_valid = 1; req_addr = 32'h0000_0020; req_we = 1; req_size = 2'd2; req_wdata = 32'h0BAD_0BAD;
    mem_ready = 0;
    tick;
    req_valid = 0;
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL rstmid_issue got=%b exp=1", mem_valid); end
    #2 rst = 0;
    #1;
    checks++; if ({mem_valid, req_ready, resp_valid} !== 3'b010) begin failures++; $display("FAIL rstmid_async got valid=%b ready=%b resp=%b exp=0/1/0", mem_valid, req_ready, resp_valid); end
    tick;
    rst = 1;
    tick;
    checks++; if ({mem_valid, req_ready, resp_valid} !== 3'b010) begin failures++; $display("FAIL rstmid_after got valid=%b ready=%b resp=%b exp=0/1/0", mem_valid, req_ready, resp_valid); end
    $display("reset mid-transaction: store abandoned");
    do_store("post_reset", 32'h0000_0040, 2'd2, 32'h1234_5678, 0, 4'b1111, 32'h1234_5678);
  endtask

  initial begin
    test_reset;
    do_store("byte", 32'h0000_1003, 2'd0, 32'h0000_00AB, 0, 4'b1000, 32'hABAB_ABAB);
    do_store("half", 32'h0000_0002, 2'd1, 32'h5555_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
    do_store("busy_word", 32'h0000_0008, 2'd2, 32'hA5A5_0F0F, 2, 4'b1111, 32'hA5A5_0F0F);
    do_load("half_s", 32'h0000_2002, 2'd1, 1'b0, 32'h8001_1234, 0, 3, 4'b1100, 32'hFFFF_8001);
    do_load("half_u", 32'h0000_2002, 2'd1, 1'b1, 32'h8001_1234, 0, 3, 4'b1100, 32'h0000_8001);
    do_load("byte_s", 32'h0000_0001, 2'd0, 1'b0, 32'h0000_F500, 0, 1, 4'b0010, 32'hFFFF_FFF5);
    do_load("word", 32'h0000_0004, 2'd2, 1'b1, 32'h8765_4321, 0, 1, 4'b1111, 32'h8765_4321);
    do_load("byte_u_late", 32'h0000_0003, 2'd0, 1'b1, 32'h9C00_0000, 2, 1, 4'b1000, 32'h0000_009C);
    do_load("half_pos", 32'h0000_0000, 2'd1, 1'b0, 32'h1234_7FFF, 0, 2, 4'b0011, 32'h0000_7FFF);
    do_err("mis_word_st", 32'h0000_0006, 1'b1, 2'd2);
    do_err("size3_ld", 32'h0000_0000, 1'b0, 2'd3);
    do_err("mis_half_ld", 32'h0000_0001, 1'b0, 2'd1);
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
